convolutor_stream_p: RTL
========================

Name: convolutor_stream_p

Overview:
Parametrised second-generation 1-D convolution coprocessor. Computes Z[k] = sum over i of X[i]*Y[k-i], for k = 0 .. sizeX+sizeY-2.
- Differences from the first generation: X comes from an external memory port (no internal ROM), and sizeX is set at runtime.
- Uses a pipelined MAC that issues one operand pair per cycle.
- Sits between the X/Y operand memories and the Z result memory, under host start/busy/done control.

Parameters:
- ADDR_WIDTH, 5: width of X/Y address and size buses. Maximum sequence length is 2^ADDR_WIDTH-1.
- DATA_WIDTH, 8: width of X/Y samples.
- ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH: width of the accumulator and dataZ. Sized so the sum cannot overflow.

Ports:
- clk  in  1  main clock; all state updates on rising edge
- rst_h  in  1  asynchronous, active-high reset
- start  in  1  level, sampled only in IDLE
- sizeX  in  ADDR_WIDTH  X length; latched when start is accepted
- sizeY  in  ADDR_WIDTH  Y length; latched when start is accepted
- memX_addr  out  ADDR_WIDTH  X memory read address
- dataX  in  DATA_WIDTH  X read data; valid 1 cycle after memX_addr
- memY_addr  out  ADDR_WIDTH  Y memory read address
- dataY  in  DATA_WIDTH  Y read data; valid 1 cycle after memY_addr
- memZ_addr  out  ADDR_WIDTH+1  Z write address, equal to k
- dataZ  out  ACC_WIDTH  Z write data
- writeZ  out  1  Z write strobe; single-cycle pulse
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  single-cycle completion pulse

Behaviour:
- Reset: rst_h forces the FSM to IDLE immediately, asynchronously. All outputs, counters, the accumulator and latched sizes go to 0. This applies mid-operation as well; no partial Z write completes.
- States: IDLE, SETUP, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 latches sizeX/sizeY and moves to SETUP.
  - start=0 stays in IDLE.
  - start is ignored in every other state.
- SETUP (1 cycle):
  - k=0, accumulator cleared.
  - If either latched size is 0, go to DONE (no writes). Otherwise go to ISSUE.
- ISSUE:
  - On entry for diagonal k: i_lo = max(0, k-sizeY+1), i_hi = min(k, sizeX-1), n = i_hi-i_lo+1.
  - Each cycle drives memX_addr=i and memY_addr=k-i, starting at i=i_lo and incrementing i. X rises while Y falls.
  - Lasts exactly n cycles, then goes to DRAIN.
- MAC pipeline:
  - Stage 1: read data returns.
  - Stage 2: product register.
  - Stage 3: accumulator add.
- DRAIN: exactly 2 cycles for the pipeline to flush, then WRITE.
- WRITE (1 cycle):
  - writeZ=1, memZ_addr=k, dataZ = final accumulator value.
  - Accumulator cleared in the same cycle.
  - If k = sizeX+sizeY-2, go to DONE. Otherwise k+1 and go to ISSUE.
- DONE: done=1 for 1 cycle, busy=0, then IDLE.
  - If start is still high in IDLE, a new run begins; no extra idle cycle is required.
- Latency:
  - Busy cycles = 1 + sizeX*sizeY + 3*(sizeX+sizeY-1).
  - Diagonal k costs n_k+3 cycles.
- Address/data hold rules:
  - memX_addr/memY_addr hold their last value outside ISSUE.
  - dataZ and memZ_addr hold their last written values until the next WRITE or reset.
- Arithmetic: unsigned by default. Product is 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH. No saturation is needed because the width guarantees no overflow.
- Size range: sizeX and sizeY span the full 0..2^ADDR_WIDTH-1. k never exceeds 2^(ADDR_WIDTH+1)-3, so memZ_addr never wraps.

Optional Feature:
- CONVOLUTOR_SIGNED_EN defined:
  - dataX/dataY are two's complement.
  - Products are signed 2*DATA_WIDTH.
  - Sign-extended to ACC_WIDTH before accumulation; dataZ is two's complement.
- Undefined: all arithmetic is unsigned, as above.
- Timing is identical in both builds.

Test Plan:
1. X=[1,2,3], Y=[1,1], sizeX=3, sizeY=2, start pulse.
   - Writes Z[0..3] = 1,3,5,3 in address order: 4 writeZ pulses.
   - busy high 19 cycles, then done for 1 cycle.
2. sizeX=1, sizeY=1, X=[7], Y=[9].
   - One write, Z[0]=63, memZ_addr=0.
   - busy 5 cycles.
3. Default parameters, all X/Y = 255, sizeX=sizeY=31.
   - Z[30] = 2015775; Z[0] = Z[60] = 65025.
   - 61 writes; no overflow in 21-bit dataZ.
4. sizeX=0, sizeY=5.
   - busy 1 cycle (SETUP), no writeZ, done pulse.
   - Then sizeY=0, sizeX=5 gives the same result.
5. Start with sizeX=sizeY=4; assert rst_h during ISSUE of k=2.
   - All outputs 0 asynchronously; FSM in IDLE.
   - Toggling start while busy on a fresh run causes no restart.
   - Rerun gives correct Z.
6. CONVOLUTOR_SIGNED_EN defined, X=[0xFF,0x02], Y=[0x03].
   - Z[0] = 0x1FFFFD (-3), Z[1] = 0x000006 (6).

Source files
------------

// File: rtl/convolutor_stream_p.sv
// convolutor_stream_p: 1-D convolution Z = X*Y streamed from external X/Y memories into Z memory.
// Define CONVOLUTOR_SIGNED_EN for two's-complement operands and result (timing unchanged).
module convolutor_stream_p #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_h,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] sizeX,
  input  logic [ADDR_WIDTH-1:0] sizeY,
  output logic [ADDR_WIDTH-1:0] memX_addr,
  input  logic [DATA_WIDTH-1:0] dataX,
  output logic [ADDR_WIDTH-1:0] memY_addr,
  input  logic [DATA_WIDTH-1:0] dataY,
  output logic [ADDR_WIDTH:0]   memZ_addr,
  output logic [ACC_WIDTH-1:0]  dataZ,
  output logic                  writeZ,
  output logic                  busy,
  output logic                  done
);
  localparam int AW = ADDR_WIDTH;
  localparam int PW = 2*DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, DRAIN, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] sx_q, sy_q, x_q, x_d, y_q, y_d;
  logic [AW:0] k_q, k_d, k_nxt, k_last, i_lo, i_hi, y_lo, zaddr_q, sx_w, sy_w;
  logic [PW-1:0] prod_q, prod_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, dz_q, prod_ext;
  logic v1_q, dr_q, issue_last;
  assign sx_w = {1'b0, sx_q};
  assign sy_w = {1'b0, sy_q};
  assign k_last = sx_w + sy_w - (AW+1)'(2);
  // Diagonal about to be entered: 0 from SETUP, k+1 from WRITE
  assign k_nxt = (state_q == WRITE) ? k_q + (AW+1)'(1) : '0;
  assign i_lo = (k_nxt + (AW+1)'(1) > sy_w) ? k_nxt + (AW+1)'(1) - sy_w : '0;
  assign y_lo = k_nxt - i_lo;
  assign i_hi = (k_q < sx_w) ? k_q : sx_w - (AW+1)'(1);
  assign issue_last = ({1'b0, x_q} == i_hi);
`ifdef CONVOLUTOR_SIGNED_EN
  logic signed [PW-1:0] xs, ys;
  assign xs = PW'($signed(dataX));
  assign ys = PW'($signed(dataY));
  assign prod_d = v1_q ? PW'(xs * ys) : '0;
  assign prod_ext = ACC_WIDTH'($signed(prod_q));
`else
  assign prod_d = v1_q ? PW'(dataX) * PW'(dataY) : '0;
  assign prod_ext = ACC_WIDTH'(prod_q);
`endif
  always_comb begin
    state_d = state_q;
    k_d = (state_q == SETUP) ? '0 : k_q;
    x_d = x_q;
    y_d = y_q;
    case (state_q)
      IDLE:    state_d = start ? SETUP : IDLE;
      SETUP:   state_d = (sx_q == '0 || sy_q == '0) ? DONE : ISSUE;
      ISSUE:   state_d = issue_last ? DRAIN : ISSUE;
      DRAIN:   state_d = dr_q ? WRITE : DRAIN;
      WRITE:   state_d = (k_q == k_last) ? DONE : ISSUE;
      default: state_d = IDLE;
    endcase
    if (state_d == ISSUE && state_q != ISSUE) begin
      k_d = k_nxt;
      x_d = i_lo[AW-1:0];
      y_d = y_lo[AW-1:0];
    end else if (state_q == ISSUE && !issue_last) begin
      x_d = x_q + 1'b1;
      y_d = y_q - 1'b1;
    end
    acc_d = (state_q == SETUP || state_q == WRITE) ? '0 : acc_q + prod_ext;
  end
  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      state_q <= IDLE;
      sx_q <= '0;
      sy_q <= '0;
      k_q <= '0;
      x_q <= '0;
      y_q <= '0;
      v1_q <= 1'b0;
      dr_q <= 1'b0;
      prod_q <= '0;
      acc_q <= '0;
      dz_q <= '0;
      zaddr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        sx_q <= sizeX;
        sy_q <= sizeY;
      end
      k_q <= k_d;
      x_q <= x_d;
      y_q <= y_d;
      v1_q <= (state_q == ISSUE);
      dr_q <= (state_q == DRAIN) && !dr_q;
      prod_q <= prod_d;
      acc_q <= acc_d;
      if (state_q == WRITE) begin
        dz_q <= acc_q;
        zaddr_q <= k_q;
      end
    end
  end
  assign memX_addr = x_q;
  assign memY_addr = y_q;
  assign writeZ = (state_q == WRITE);
  assign busy = (state_q != IDLE) && (state_q != DONE);
  assign done = (state_q == DONE);
  assign dataZ = writeZ ? acc_q : dz_q;
  assign memZ_addr = writeZ ? k_q : zaddr_q;
endmodule
